// File: rtl/bus_sram_slave.sv
// bus_sram_slave: word-organised synchronous SRAM slave with programmable wait states and one-cycle bdone/berror response
// Ports: clk, rst_n (async active-low); ss/bstart/addr/wdata/tsize/ttype request from interconnect;
//        rdata/bdone/berror registered response, rdata and berror only meaningful while bdone=1.
module bus_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ss,
    input  logic        bstart,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  tsize,
    input  logic        ttype,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        berror
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [27:0] a_q;
    logic [31:0] wd_q;
    logic [1:0]  sz_q;
    logic        wr_q;
    logic [31:0] mem [DEPTH];
    logic [27:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_wr, accept, commit, err;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic        unused_addr;
    assign unused_addr = ^addr[31:28];
    always_comb begin
        r_addr  = state == IDLE ? addr[27:0] : a_q;
        r_wdata = state == IDLE ? wdata : wd_q;
        r_size  = state == IDLE ? tsize : sz_q;
        r_wr    = state == IDLE ? ttype : wr_q;
        accept  = state == IDLE && ss && bstart;
        commit  = rst_n && (accept ? WAIT_STATES == 0 : state == WAIT && cnt == 4'd1);
        err     = r_size == 2'd3 || (r_size == 2'd1 && r_addr[0]) || (r_size == 2'd2 && r_addr[1:0] != 2'd0)
                  || {6'd0, r_addr[27:2]} >= 32'(DEPTH);
        idx     = r_addr[AW+1:2];
        be      = r_size == 2'd0 ? 4'b0001 << r_addr[1:0] : r_size == 2'd1 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    always_ff @(posedge clk)
        if (commit && r_wr && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= r_wdata[8*i +: 8];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            a_q    <= '0;
            wd_q   <= '0;
            sz_q   <= '0;
            wr_q   <= 1'b0;
            rdata  <= '0;
            bdone  <= 1'b0;
            berror <= 1'b0;
        end else begin
            bdone  <= commit;
            berror <= commit && err;
            rdata  <= commit && !err && !r_wr ? mem[idx] : '0;
            case (state)
                IDLE: if (accept) begin
                    a_q   <= addr[27:0];
                    wd_q  <= wdata;
                    sz_q  <= tsize;
                    wr_q  <= ttype;
                    cnt   <= WAIT_STATES[3:0];
                    state <= WAIT_STATES == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: directed checks of bus_sram_slave with one and zero wait states
module tb_bus_sram_slave;
    logic        clk = 0, rst_n = 1, ss = 0, bstart = 0, ttype = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [1:0]  tsize = 0;
    logic [31:0] rdata1, rdata0;
    logic        bdone1, berror1, bdone0, berror0;
    int nvec = 0, errs = 0;
    always #5 clk = ~clk;
    bus_sram_slave #(.DEPTH(1024), .WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .ss(ss), .bstart(bstart),
        .addr(addr), .wdata(wdata), .tsize(tsize), .ttype(ttype), .rdata(rdata1), .bdone(bdone1), .berror(berror1));
    bus_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .ss(ss), .bstart(bstart),
        .addr(addr), .wdata(wdata), .tsize(tsize), .ttype(ttype), .rdata(rdata0), .bdone(bdone0), .berror(berror0));

    // Issues one transfer, returns response, edges from accept to bdone, and bdone one cycle later.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz, input logic wr, input bit w0,
                        output logic [31:0] rd, output logic er, output int lat, output logic tail);
        addr = a; wdata = wd; tsize = sz; ttype = wr; ss = 1; bstart = 1;
        @(posedge clk); #1;
        bstart = 0; ss = 0; lat = 1;
        while (!(w0 ? bdone0 : bdone1) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = w0 ? rdata0 : rdata1;
        er = w0 ? berror0 : berror1;
        @(posedge clk); #1;
        tail = w0 ? bdone0 : bdone1;
    endtask

    task automatic test_reset();
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (bdone1 !== 1'b0) begin errs++; $display("FAIL reset_bdone: got %b want 0", bdone1); end
        nvec++; if (berror1 !== 1'b0) begin errs++; $display("FAIL reset_berror: got %b want 0", berror1); end
        nvec++; if (rdata1 !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", rdata1); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, tl; int lat;
        xfer(32'hF0000010, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, rd, er, lat, tl);
        nvec++; if (lat != 2) begin errs++; $display("FAIL word_wr_latency: got %0d want 2", lat); end
        nvec++; if (er !== 1'b0) begin errs++; $display("FAIL word_wr_berror: got %b want 0", er); end
        nvec++; if (rd !== 32'h0) begin errs++; $display("FAIL word_wr_rdata: got %h want 0", rd); end
        nvec++; if (tl !== 1'b0) begin errs++; $display("FAIL word_wr_single_pulse: got %b want 0", tl); end
        nvec++; if (rdata1 !== 32'h0) begin errs++; $display("FAIL rdata_idle: got %h want 0", rdata1); end
        xfer(32'hF0000010, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL word_rd_data: got %h want deadbeef", rd); end
        nvec++; if (er !== 1'b0) begin errs++; $display("FAIL word_rd_berror: got %b want 0", er); end
        nvec++; if (lat != 2) begin errs++; $display("FAIL word_rd_latency: got %0d want 2", lat); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er, tl; int lat;
        xfer(32'hF0000010, 32'h11223344, 2'd2, 1'b1, 1'b0, rd, er, lat, tl);
        xfer(32'hF0000013, 32'hAA000000, 2'd0, 1'b1, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b0) begin errs++; $display("FAIL byte_wr_berror: got %b want 0", er); end
        xfer(32'hF0000010, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'hAA223344) begin errs++; $display("FAIL byte_rd: got %h want aa223344", rd); end
        xfer(32'hF0000010, 32'h00005566, 2'd1, 1'b1, 1'b0, rd, er, lat, tl);
        xfer(32'hF0000012, 32'h0, 2'd1, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'hAA225566) begin errs++; $display("FAIL half_rd: got %h want aa225566", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er, tl; int lat;
        xfer(32'hF0000000, 32'h01020304, 2'd2, 1'b1, 1'b0, rd, er, lat, tl);
        xfer(32'hF0000002, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL mis_word_berror: got %b want 1", er); end
        nvec++; if (rd !== 32'h0) begin errs++; $display("FAIL mis_word_rdata: got %h want 0", rd); end
        nvec++; if (lat != 2) begin errs++; $display("FAIL mis_word_latency: got %0d want 2", lat); end
        xfer(32'hF0000001, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL mis_half_berror: got %b want 1", er); end
        xfer(32'hF0000010, 32'hFFFFFFFF, 2'd3, 1'b1, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL tsize3_berror: got %b want 1", er); end
        xfer(32'hF0000000, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'h01020304) begin errs++; $display("FAIL mis_half_unchanged: got %h want 01020304", rd); end
        xfer(32'hF0000010, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'hAA225566) begin errs++; $display("FAIL tsize3_unchanged: got %h want aa225566", rd); end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er, tl; int lat;
        xfer(32'hF0001000, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL oor_rd_berror: got %b want 1", er); end
        xfer(32'hF0001000, 32'h99999999, 2'd2, 1'b1, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL oor_wr_berror: got %b want 1", er); end
        xfer(32'hF0000000, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'h01020304) begin errs++; $display("FAIL oor_no_alias: got %h want 01020304", rd); end
        xfer(32'hF0000FFC, 32'h0BADF00D, 2'd2, 1'b1, 1'b0, rd, er, lat, tl);
        xfer(32'hF0000FFC, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (er !== 1'b0) begin errs++; $display("FAIL last_word_berror: got %b want 0", er); end
        nvec++; if (rd !== 32'h0BADF00D) begin errs++; $display("FAIL last_word_rd: got %h want 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, rq; logic er, tl; int lat, n;
        addr = 32'hF0000010; tsize = 2'd2; ttype = 1'b0; ss = 1; bstart = 1;
        @(posedge clk); #1;
        addr = 32'hF0000FFC; wdata = 32'h12345678; ttype = 1'b1;
        @(posedge clk); #1;
        bstart = 0; ss = 0;
        n = int'(bdone1); rq = rdata1;
        repeat (4) begin @(posedge clk); #1; n += int'(bdone1); end
        nvec++; if (n != 1) begin errs++; $display("FAIL busy_ignore_pulses: got %0d want 1", n); end
        nvec++; if (rq !== 32'hAA225566) begin errs++; $display("FAIL busy_first_rdata: got %h want aa225566", rq); end
        xfer(32'hF0000FFC, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'h0BADF00D) begin errs++; $display("FAIL busy_no_write: got %h want 0badf00d", rd); end
        xfer(32'hF0000000, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (lat != 2) begin errs++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        nvec++; if (rd !== 32'h01020304) begin errs++; $display("FAIL b2b_rdata: got %h want 01020304", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, tl; int lat, n;
        addr = 32'hF0000010; wdata = 32'hCAFEF00D; tsize = 2'd2; ttype = 1'b1; ss = 1; bstart = 1;
        @(posedge clk); #1;
        bstart = 0; ss = 0;
        #1 rst_n = 0;
        @(posedge clk); #1;
        n = int'(bdone1);
        rst_n = 1;
        repeat (4) begin @(posedge clk); #1; n += int'(bdone1); end
        nvec++; if (n != 0) begin errs++; $display("FAIL rst_mid_bdone: got %0d want 0", n); end
        xfer(32'hF0000010, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat, tl);
        nvec++; if (rd !== 32'hAA225566) begin errs++; $display("FAIL rst_mid_dropped: got %h want aa225566", rd); end
    endtask

    task automatic test_ws0();
        logic [31:0] rd; logic er, tl; int lat;
        xfer(32'hF0000020, 32'h76543210, 2'd2, 1'b1, 1'b1, rd, er, lat, tl);
        nvec++; if (lat != 1) begin errs++; $display("FAIL ws0_wr_latency: got %0d want 1", lat); end
        nvec++; if (tl !== 1'b0) begin errs++; $display("FAIL ws0_single_pulse: got %b want 0", tl); end
        xfer(32'hF0000020, 32'h0, 2'd2, 1'b0, 1'b1, rd, er, lat, tl);
        nvec++; if (lat != 1) begin errs++; $display("FAIL ws0_rd_latency: got %0d want 1", lat); end
        nvec++; if (rd !== 32'h76543210) begin errs++; $display("FAIL ws0_rd_data: got %h want 76543210", rd); end
        xfer(32'hF0001000, 32'h0, 2'd2, 1'b0, 1'b1, rd, er, lat, tl);
        nvec++; if (er !== 1'b1) begin errs++; $display("FAIL ws0_oor_berror: got %b want 1", er); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_ws0();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
